// File: rtl/tb_segmenter.sv
// -----------------------------------------------------------------------------
// tb_segmenter
//
// Code-block segmentation front-end. A transport-block size is latched with
// wreq_size/tb_size_in. The bit-serial transport block (wreq_data/tb_in) is
// buffered in a small bit FIFO. It is re-emitted as a sequence of code blocks
// of K_LARGE or K_SMALL bits. The final block is zero-padded when fewer real
// bits remain than its size.
//
// Ports
//   clk, reset             : single rising-edge clock, synchronous active-high
//                            reset
//   wreq_size, tb_size_in  : one-cycle strobe latching the transport-block size
//   wreq_data, tb_in       : one serial input bit per strobe
//   cb_ready               : downstream accepts cb_bit this cycle
//   cb_valid, cb_bit       : output bit stream (data or pad zero)
//   cb_sof, cb_eof         : first / last bit of a code block
//   cb_size, cb_index      : size and 0-based index of the current block
//   cb_pad                 : current bit is a pad zero
//   tb_done                : one-cycle pulse after the last block's eof
//   busy                   : transport block in progress
//   err                    : sticky error (bad size, size while busy,
//                            FIFO overflow)
// -----------------------------------------------------------------------------
module tb_segmenter #(
    parameter int SIZE_W     = 16,
    parameter int K_LARGE    = 6144,
    parameter int K_SMALL    = 1056,
    parameter int FIFO_DEPTH = 16,
    parameter int IDX_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wreq_size,
    input  logic [SIZE_W-1:0] tb_size_in,
    input  logic              wreq_data,
    input  logic              tb_in,
    input  logic              cb_ready,
    output logic              cb_valid,
    output logic              cb_bit,
    output logic              cb_sof,
    output logic              cb_eof,
    output logic [SIZE_W-1:0] cb_size,
    output logic [IDX_W-1:0]  cb_index,
    output logic              cb_pad,
    output logic              tb_done,
    output logic              busy,
    output logic              err
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [SIZE_W-1:0] KL      = SIZE_W'(K_LARGE);
    localparam logic [SIZE_W-1:0] KS      = SIZE_W'(K_SMALL);
    localparam logic [SIZE_W-1:0] ONE     = SIZE_W'(1);
    localparam logic [PTR_W:0]    PTR_ONE = (PTR_W+1)'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Transport-block bookkeeping
    logic [SIZE_W-1:0] tb_size;    // latched transport-block size
    logic [SIZE_W-1:0] in_count;   // input bits accepted so far
    logic [SIZE_W-1:0] rem;        // real bits not yet assigned to a block
    logic [SIZE_W-1:0] real_cnt;   // real bits in the current block
    logic [SIZE_W-1:0] bit_cnt;    // bits emitted in the current block
    logic              first_blk;  // next LOAD starts block index 0

    // Input bit FIFO. Pointers carry one extra wrap bit so full and empty
    // can be told apart.
    logic             fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_head;

    logic is_idle, size_accept, size_reject, in_accept, overflow;
    logic [SIZE_W-1:0] blk_size, blk_real;
    logic last_real, last_bit;

    assign is_idle     = (state == S_IDLE);
    assign size_accept = wreq_size && is_idle && (tb_size_in != '0);
    assign size_reject = wreq_size && !size_accept;

    // Bits beyond the declared size, or outside a transport block, are
    // dropped without raising err.
    assign in_accept = wreq_data && !is_idle && (in_count < tb_size);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_push  = in_accept && !fifo_full;
    assign overflow   = in_accept && fifo_full;
    assign fifo_pop   = (state == S_RUN) && !fifo_empty && cb_ready;
    assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    // Block sizing from the remaining real bits: a large block while at least
    // K_LARGE remain, otherwise a small block holding up to K_SMALL of them.
    assign blk_size = (rem >= KL) ? KL : KS;
    assign blk_real = (rem < blk_size) ? rem : blk_size;

    assign last_real = (bit_cnt == real_cnt - ONE);
    assign last_bit  = (bit_cnt == cb_size - ONE);

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cb_valid  = 1'b0;
        cb_bit    = 1'b0;
        cb_sof    = 1'b0;
        cb_eof    = 1'b0;
        cb_pad    = 1'b0;
        tb_done   = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (size_accept) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_RUN;
            S_RUN: begin
                cb_valid = !fifo_empty;
                cb_bit   = !fifo_empty && fifo_head;
                cb_sof   = !fifo_empty && (bit_cnt == '0);
                cb_eof   = !fifo_empty && last_bit;
                if (fifo_pop && last_real) begin
                    if (real_cnt != cb_size) state_nxt = S_PAD;
                    else if (rem != '0)      state_nxt = S_LOAD;
                    else                     state_nxt = S_DONE;
                end
            end
            S_PAD: begin
                // Pad zeros need no FIFO data.
                cb_valid = 1'b1;
                cb_pad   = 1'b1;
                cb_sof   = (bit_cnt == '0);
                cb_eof   = last_bit;
                if (cb_ready && last_bit)
                    state_nxt = (rem != '0) ? S_LOAD : S_DONE;
            end
            S_DONE: begin
                tb_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the bit storage has no reset; only the pointers do. Stale bits in
    // the array are never visible because an empty FIFO gates the output.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= tb_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tb_size   <= '0;
            in_count  <= '0;
            rem       <= '0;
            real_cnt  <= '0;
            bit_cnt   <= '0;
            first_blk <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cb_size   <= '0;
            cb_index  <= '0;
            err       <= 1'b0;
        end else begin
            if (size_accept) begin
                // A new transport block starts from a clean input side.
                tb_size   <= tb_size_in;
                rem       <= tb_size_in;
                in_count  <= '0;
                first_blk <= 1'b1;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (in_accept) in_count <= in_count + ONE;
                if (fifo_push) wr_ptr   <= wr_ptr + PTR_ONE;
                if (fifo_pop)  rd_ptr   <= rd_ptr + PTR_ONE;
            end

            if (state == S_LOAD) begin
                cb_size   <= blk_size;
                real_cnt  <= blk_real;
                rem       <= rem - blk_real;
                bit_cnt   <= '0;
                cb_index  <= first_blk ? '0 : cb_index + IDX_ONE;
                first_blk <= 1'b0;
            end else if (fifo_pop || (state == S_PAD && cb_ready)) begin
                bit_cnt <= bit_cnt + ONE;
            end

            if (size_accept)                  err <= 1'b0;
            else if (size_reject || overflow) err <= 1'b1;
        end
    end

endmodule
